// File: rtl/serial_frame_encoder.sv
// Byte-to-serial framing stage: start(1), data MSB first, optional parity, stop(0).
// Define ENCODER_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_frame_encoder #(
    parameter int BIT_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] parallelIn,
    input  logic       loadValid,
    output logic       loadReady,
    output logic       serialOut,
    output logic       busy,
    output logic       frameDone
);

    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef ENCODER_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state, stateNext;
    logic [CW-1:0] cycleCount, cycleNext;
    logic [2:0] bitCount, bitNext;
    logic [7:0] shiftReg, shiftNext;
    logic serialNext, busyNext, doneNext, readyNext;
    logic accept, bitEnd;

`ifdef ENCODER_PARITY_EN
    logic parityBit, parityNext;
`endif

    assign accept = loadValid && loadReady;
    assign bitEnd = (cycleCount == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cycleCount <= '0;
            bitCount   <= 3'd7;
            shiftReg   <= 8'h00;
            serialOut  <= 1'b0;
            busy       <= 1'b0;
            frameDone  <= 1'b0;
            loadReady  <= 1'b0;
`ifdef ENCODER_PARITY_EN
            parityBit  <= 1'b0;
`endif
        end else begin
            state      <= stateNext;
            cycleCount <= cycleNext;
            bitCount   <= bitNext;
            shiftReg   <= shiftNext;
            serialOut  <= serialNext;
            busy       <= busyNext;
            frameDone  <= doneNext;
            loadReady  <= readyNext;
`ifdef ENCODER_PARITY_EN
            parityBit  <= parityNext;
`endif
        end
    end

    always_comb begin
        stateNext = state;
        cycleNext = cycleCount;
        bitNext   = bitCount;
        shiftNext = shiftReg;
`ifdef ENCODER_PARITY_EN
        parityNext = parityBit;
`endif
        if (state != IDLE) begin
            cycleNext = bitEnd ? '0 : cycleCount + 1'b1;
        end
        unique case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = START;
                    cycleNext = '0;
                    shiftNext = parallelIn;
`ifdef ENCODER_PARITY_EN
                    parityNext = ^parallelIn;
`endif
                end
            end
            START: begin
                if (bitEnd) begin
                    stateNext = DATA;
                    bitNext   = 3'd7;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    shiftNext = {shiftReg[6:0], 1'b0};
                    if (bitCount == 3'd0) begin
`ifdef ENCODER_PARITY_EN
                        stateNext = PARITY;
`else
                        stateNext = STOP;
`endif
                    end else begin
                        bitNext = bitCount - 3'd1;
                    end
                end
            end
`ifdef ENCODER_PARITY_EN
            PARITY: begin
                if (bitEnd) stateNext = STOP;
            end
`endif
            STOP: begin
                if (bitEnd) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register in step with it.
    always_comb begin
        serialNext = 1'b0;
        unique case (stateNext)
            START:   serialNext = 1'b1;
            DATA:    serialNext = shiftNext[7];
`ifdef ENCODER_PARITY_EN
            PARITY:  serialNext = parityNext;
`endif
            default: serialNext = 1'b0;
        endcase
        busyNext  = (stateNext != IDLE);
        readyNext = (stateNext == IDLE);
        doneNext  = (stateNext == STOP) && (cycleNext == LAST);
    end

endmodule

// File: tb/tb_serial_frame_encoder.sv
// Bench for serial_frame_encoder: two instances (1 and 3 clocks per bit)
// checked against a frame-level reference model.
module tb_serial_frame_encoder;

    typedef logic bitq_t[$];

    logic clock;
    logic reset;
    logic [7:0] pIn[2];
    logic lv[2];
    logic lr[2];
    logic so[2];
    logic bz[2];
    logic fd[2];

    int nAssert = 0;
    int nFail = 0;

    serial_frame_encoder #(.BIT_CYCLES(1)) dut1 (
        .clock(clock), .reset(reset),
        .parallelIn(pIn[0]), .loadValid(lv[0]),
        .loadReady(lr[0]), .serialOut(so[0]),
        .busy(bz[0]), .frameDone(fd[0])
    );

    serial_frame_encoder #(.BIT_CYCLES(3)) dut3 (
        .clock(clock), .reset(reset),
        .parallelIn(pIn[1]), .loadValid(lv[1]),
        .loadReady(lr[1]), .serialOut(so[1]),
        .busy(bz[1]), .frameDone(fd[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int i,
                       input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s[%0d]: observed %0h expected %0h",
                   tag, i, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic bitq_t buildFrame(input logic [7:0] d, input int bc);
        bitq_t levels;
        bitq_t q;
        levels.push_back(1'b1);
        for (int k = 7; k >= 0; k--) levels.push_back(d[k]);
`ifdef ENCODER_PARITY_EN
        levels.push_back(^d);
`endif
        levels.push_back(1'b0);
        foreach (levels[n]) repeat (bc) q.push_back(levels[n]);
        return q;
    endfunction

    task automatic sendFrame(input int i, input logic [7:0] d, input bit keep);
        int bc;
        bitq_t q;
        int busyCyc;
        int waitN;
        logic [7:0] rx;
        bc = (i == 0) ? 1 : 3;
        q = buildFrame(d, bc);
        waitN = 0;
        while (lr[i] !== 1'b1 && waitN < 40) begin
            step();
            waitN++;
        end
        chk("readyBeforeAccept", i, lr[i], 1);
        pIn[i] = d;
        lv[i] = 1'b1;
        step();
        if (!keep) lv[i] = 1'b0;
        busyCyc = 0;
        rx = 8'h00;
        for (int j = 0; j < q.size(); j++) begin
            pIn[i] = 8'($urandom);
            chk("serialOut", i, so[i], q[j]);
            chk("frameDone", i, fd[i], (j == q.size() - 1));
            chk("loadReady", i, lr[i], 0);
            if (bz[i] === 1'b1) busyCyc++;
            if ((j % bc) == bc / 2 && j / bc >= 1 && j / bc <= 8)
                rx = {rx[6:0], so[i]};
            step();
        end
        chk("busyCycles", i, busyCyc, q.size());
        chk("decodedByte", i, rx, d);
        chk("idleBusy", i, bz[i], 0);
        chk("idleReady", i, lr[i], 1);
        chk("idleLine", i, so[i], 0);
        chk("idleDone", i, fd[i], 0);
    endtask

    initial begin
        int sel;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            lv[i] = 1'b0;
            pIn[i] = 8'h00;
        end
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            chk("rstLine", i, so[i], 0);
            chk("rstBusy", i, bz[i], 0);
            chk("rstDone", i, fd[i], 0);
            chk("rstReady", i, lr[i], 0);
        end
        reset = 1'b0;
        step();
        for (int i = 0; i < 2; i++) chk("releaseReady", i, lr[i], 1);

        for (int i = 0; i < 2; i++) begin
            pIn[i] = 8'hFF;
            lv[i] = 1'b1;
        end
        step();
        for (int i = 0; i < 2; i++) begin
            lv[i] = 1'b0;
            chk("midFrameBusy", i, bz[i], 1);
        end
        step();
        reset = 1'b1;
        repeat (3) begin
            step();
            for (int i = 0; i < 2; i++) begin
                chk("abortLine", i, so[i], 0);
                chk("abortBusy", i, bz[i], 0);
                chk("abortReady", i, lr[i], 0);
                chk("abortDone", i, fd[i], 0);
            end
        end
        reset = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            chk("abortReleaseReady", i, lr[i], 1);
            chk("abortReleaseBusy", i, bz[i], 0);
        end

        sendFrame(0, 8'hA5, 1'b0);
        sendFrame(1, 8'h07, 1'b0);
        sendFrame(1, 8'hA5, 1'b0);
        sendFrame(0, 8'h3C, 1'b1);
        sendFrame(0, 8'hC3, 1'b0);
        sendFrame(1, 8'h3C, 1'b1);
        sendFrame(1, 8'hC3, 1'b0);
        sendFrame(0, 8'h5A, 1'b0);
        sendFrame(0, 8'h00, 1'b0);
        sendFrame(1, 8'hFF, 1'b0);

        for (int r = 0; r < 6; r++) begin
            sel = int'($urandom_range(0, 1));
            sendFrame(sel, 8'($urandom), 1'b1);
            sendFrame(sel, 8'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAssert, nFail);
        $finish;
    end

endmodule
